// File: rtl/tag_sort_pipe_ctrl_if.sv
// Issue-side bundle between the scheduler front end and the tag sorter issue controller.
interface tag_sort_pipe_ctrl_if #(
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned TAG_W      = 12,
    parameter int unsigned CNT_W      = 9
);
    logic                  ins_req;
    logic [TAG_W-1:0]      ins_tag;
    logic                  ins_ack;
    logic                  deq_req;
    logic                  deq_ack;
    logic                  stall;
    logic [1:0]            issue_op;
    logic [TAG_W-1:0]      issue_tag;
    logic [NUM_STAGES-1:0] stage_ena;
    logic [NUM_STAGES-1:0] stage_valid;
    logic                  done_valid;
    logic [1:0]            done_op;
    logic [CNT_W-1:0]      occupancy;
    logic                  full;
    logic                  empty;
    logic                  busy;

    modport master (
        output ins_req, ins_tag, deq_req, stall,
        input  ins_ack, deq_ack, issue_op, issue_tag, stage_ena, stage_valid,
               done_valid, done_op, occupancy, full, empty, busy
    );

    modport slave (
        input  ins_req, ins_tag, deq_req, stall,
        output ins_ack, deq_ack, issue_op, issue_tag, stage_ena, stage_valid,
               done_valid, done_op, occupancy, full, empty, busy
    );
endinterface

// File: rtl/tag_sort_pipe_ctrl.sv
// Issue controller for the multibit-tree tag sorter: arbitrates insert/dequeue,
// drives stage enables and valid bits, enforces dequeue spacing, tracks occupancy.
module tag_sort_pipe_ctrl #(
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned TAG_W      = 12,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned CNT_W      = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    tag_sort_pipe_ctrl_if.slave  sp
);
    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_INS  = 2'b01;
    localparam logic [1:0] OP_DEQ  = 2'b10;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [NUM_STAGES-1:0] r_valid;
    logic [NUM_STAGES-1:0] r_is_deq;
    logic [NUM_STAGES-1:0] w_valid_nxt;
    logic [NUM_STAGES-1:0] w_is_deq_nxt;
    logic [1:0]            r_issue_op;
    logic [TAG_W-1:0]      r_issue_tag;
    logic [CNT_W-1:0]      r_occ;
    logic [CNT_W-1:0]      w_occ_nxt;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_last_deq;
    logic                  w_hazard;
    logic                  w_ins_ok;
    logic                  w_deq_ok;
    logic                  w_conflict;
    logic                  w_gnt_ins;
    logic                  w_gnt_deq;
    logic                  w_grant;

    // A dequeue must reach the last stage (bitmap updated) before the next may issue
    assign w_hazard   = |(r_valid[NUM_STAGES-2:0] & r_is_deq[NUM_STAGES-2:0]);
    assign w_ins_ok   = sp.ins_req & ~r_full & ~sp.stall;
    assign w_deq_ok   = sp.deq_req & ~r_empty & ~sp.stall & ~w_hazard;
    assign w_conflict = w_ins_ok & w_deq_ok;
    assign w_gnt_ins  = w_ins_ok & (~w_deq_ok | r_last_deq);
    assign w_gnt_deq  = w_deq_ok & (~w_ins_ok | ~r_last_deq);
    assign w_grant    = w_gnt_ins | w_gnt_deq;

    assign w_valid_nxt  = sp.stall ? r_valid  : {r_valid[NUM_STAGES-2:0], w_grant};
    assign w_is_deq_nxt = sp.stall ? r_is_deq : {r_is_deq[NUM_STAGES-2:0], w_gnt_deq};

    always_comb begin
        w_occ_nxt = r_occ;
        if (w_gnt_ins) begin
            w_occ_nxt = r_occ + CNT_W'(1);
        end else if (w_gnt_deq) begin
            w_occ_nxt = r_occ - CNT_W'(1);
        end
    end

    // RUN drops to IDLE as soon as the pipe will be empty after this edge
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_grant) w_state_nxt = RUN;
            RUN: begin
                if (sp.stall) begin
                    w_state_nxt = HOLD;
                end else if (w_valid_nxt == '0) begin
                    w_state_nxt = IDLE;
                end
            end
            HOLD: if (!sp.stall) w_state_nxt = RUN;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_valid     <= '0;
            r_is_deq    <= '0;
            r_issue_op  <= OP_NONE;
            r_issue_tag <= '0;
            r_occ       <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_last_deq  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_valid     <= w_valid_nxt;
            r_is_deq    <= w_is_deq_nxt;
            r_issue_op  <= w_gnt_ins ? OP_INS : (w_gnt_deq ? OP_DEQ : OP_NONE);
            r_issue_tag <= w_gnt_ins ? sp.ins_tag : '0;
            r_occ       <= w_occ_nxt;
            r_full      <= (w_occ_nxt == CNT_W'(DEPTH));
            r_empty     <= (w_occ_nxt == '0);
            if (w_conflict) begin
                r_last_deq <= w_gnt_deq;
            end
        end
    end

    assign sp.ins_ack     = w_gnt_ins;
    assign sp.deq_ack     = w_gnt_deq;
    assign sp.issue_op    = r_issue_op;
    assign sp.issue_tag   = r_issue_tag;
    assign sp.stage_ena   = {NUM_STAGES{~sp.stall}};
    assign sp.stage_valid = r_valid;
    assign sp.done_valid  = r_valid[NUM_STAGES-1] & ~sp.stall;
    assign sp.done_op     = r_valid[NUM_STAGES-1] ? (r_is_deq[NUM_STAGES-1] ? OP_DEQ : OP_INS) : OP_NONE;
    assign sp.occupancy   = r_occ;
    assign sp.full        = r_full;
    assign sp.empty       = r_empty;
    assign sp.busy        = (r_state != IDLE);
endmodule

// File: tb/tb_tag_sort_pipe_ctrl.sv
// Directed bench for tag_sort_pipe_ctrl: NUM_STAGES=3, DEPTH=4, inputs driven on negedge.
module tb_tag_sort_pipe_ctrl;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    tag_sort_pipe_ctrl_if #(.NUM_STAGES(3), .TAG_W(12), .CNT_W(3)) bus ();

    tag_sort_pipe_ctrl #(.NUM_STAGES(3), .TAG_W(12), .DEPTH(4), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .sp  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (bus.busy !== 1'b0 && n < 20);
        chk(tag, 32'(bus.busy), 0);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    logic [7:0] e_ins;
    logic [7:0] e_deq;
    int         e_occ[8];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.ins_req = 1'b0;
        bus.ins_tag = '0;
        bus.deq_req = 1'b0;
        bus.stall   = 1'b0;
        e_ins = 8'b0010_1101;
        e_deq = 8'b1001_0010;
        e_occ = '{2, 3, 2, 3, 4, 3, 4, 4};

        // reset state
        @(negedge clk);
        #2;
        chk("rst_valid", 32'(bus.stage_valid), 0);
        chk("rst_occ",   32'(bus.occupancy), 0);
        chk("rst_busy",  32'(bus.busy), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full",  32'(bus.full), 0);
        chk("rst_iop",   32'(bus.issue_op), 0);
        chk("rst_done",  32'(bus.done_valid), 0);
        rst = 1'b0;

        // dequeue while empty, insert in same cycle
        @(negedge clk);
        bus.ins_req = 1'b1; bus.ins_tag = 12'h123; bus.deq_req = 1'b1;
        #2;
        chk("emp_deq_ack0", 32'(bus.deq_ack), 0);
        chk("emp_ins_ack",  32'(bus.ins_ack), 1);
        @(negedge clk);
        bus.ins_req = 1'b0;
        #2;
        chk("emp_deq_ack1", 32'(bus.deq_ack), 1);
        chk("emp_ins_ack0", 32'(bus.ins_ack), 0);
        chk("emp_occ1",     32'(bus.occupancy), 1);
        chk("emp_iop",      32'(bus.issue_op), 1);
        chk("emp_itag",     32'(bus.issue_tag), 32'h123);
        @(negedge clk);
        bus.deq_req = 1'b0;
        #2;
        chk("emp_occ0",  32'(bus.occupancy), 0);
        chk("emp_empty", 32'(bus.empty), 1);
        chk("emp_iop2",  32'(bus.issue_op), 2);
        chk("emp_itag2", 32'(bus.issue_tag), 0);
        @(negedge clk); #2;
        chk("emp_done1", 32'(bus.done_valid), 1);
        chk("emp_dop1",  32'(bus.done_op), 1);
        @(negedge clk); #2;
        chk("emp_done2", 32'(bus.done_valid), 1);
        chk("emp_dop2",  32'(bus.done_op), 2);
        wait_idle("emp_idle");

        // single insert latency
        @(negedge clk);
        bus.ins_req = 1'b1; bus.ins_tag = 12'h0A5;
        #2;
        chk("one_ack",  32'(bus.ins_ack), 1);
        chk("one_busy0", 32'(bus.busy), 0);
        @(negedge clk);
        bus.ins_req = 1'b0; bus.ins_tag = '0;
        #2;
        chk("one_iop",   32'(bus.issue_op), 1);
        chk("one_itag",  32'(bus.issue_tag), 32'h0A5);
        chk("one_sv1",   32'(bus.stage_valid), 1);
        chk("one_occ",   32'(bus.occupancy), 1);
        chk("one_busy1", 32'(bus.busy), 1);
        @(negedge clk); #2;
        chk("one_sv2",   32'(bus.stage_valid), 2);
        chk("one_done0", 32'(bus.done_valid), 0);
        @(negedge clk); #2;
        chk("one_sv3",   32'(bus.stage_valid), 4);
        chk("one_done",  32'(bus.done_valid), 1);
        chk("one_dop",   32'(bus.done_op), 1);
        @(negedge clk); #2;
        chk("one_busy_end", 32'(bus.busy), 0);
        chk("one_sv_end",   32'(bus.stage_valid), 0);
        chk("one_done_end", 32'(bus.done_valid), 0);

        // fill to DEPTH, fifth insert blocked until a dequeue
        pulse_rst();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.ins_req = 1'b1; bus.ins_tag = 12'(i + 1);
            #2;
            chk($sformatf("fill_ack%0d", i), 32'(bus.ins_ack), 1);
        end
        @(negedge clk);
        bus.ins_tag = 12'h005;
        #2;
        chk("fill_full", 32'(bus.full), 1);
        chk("fill_occ4", 32'(bus.occupancy), 4);
        chk("fill_blk0", 32'(bus.ins_ack), 0);
        @(negedge clk); #2;
        chk("fill_blk1", 32'(bus.ins_ack), 0);
        @(negedge clk);
        bus.deq_req = 1'b1;
        #2;
        chk("fill_deq",  32'(bus.deq_ack), 1);
        chk("fill_blk2", 32'(bus.ins_ack), 0);
        @(negedge clk);
        bus.deq_req = 1'b0;
        #2;
        chk("fill_ack5", 32'(bus.ins_ack), 1);
        chk("fill_occ3", 32'(bus.occupancy), 3);
        chk("fill_nfull", 32'(bus.full), 0);
        @(negedge clk);
        bus.ins_req = 1'b0;
        #2;
        chk("fill_occ4b", 32'(bus.occupancy), 4);
        chk("fill_full2", 32'(bus.full), 1);
        wait_idle("fill_idle");

        // round-robin with both requests held, occupancy starting at 2
        pulse_rst();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.ins_req = 1'b1; bus.ins_tag = 12'(16 + i);
            #2;
            chk($sformatf("pre_ack%0d", i), 32'(bus.ins_ack), 1);
        end
        @(negedge clk);
        bus.ins_req = 1'b0;
        wait_idle("pre_idle");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.ins_req = 1'b1; bus.ins_tag = 12'h0B1; bus.deq_req = 1'b1;
            #2;
            chk($sformatf("rr_ins%0d", i), 32'(bus.ins_ack), 32'(e_ins[i]));
            chk($sformatf("rr_deq%0d", i), 32'(bus.deq_ack), 32'(e_deq[i]));
            chk($sformatf("rr_occ%0d", i), 32'(bus.occupancy), 32'(e_occ[i]));
        end
        @(negedge clk);
        bus.ins_req = 1'b0; bus.deq_req = 1'b0;
        #2;
        chk("rr_occ_end", 32'(bus.occupancy), 3);
        wait_idle("rr_idle");

        // two-cycle stall with ops in stages 1 and 2
        @(negedge clk);
        bus.deq_req = 1'b1;
        #2;
        chk("st_deq", 32'(bus.deq_ack), 1);
        @(negedge clk);
        bus.deq_req = 1'b0; bus.ins_req = 1'b1; bus.ins_tag = 12'h0C2;
        #2;
        chk("st_ins", 32'(bus.ins_ack), 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.stall = 1'b1;
            #2;
            chk($sformatf("st_sv%0d", i),   32'(bus.stage_valid), 3);
            chk($sformatf("st_ena%0d", i),  32'(bus.stage_ena), 0);
            chk($sformatf("st_ack%0d", i),  32'(bus.ins_ack), 0);
            chk($sformatf("st_done%0d", i), 32'(bus.done_valid), 0);
        end
        chk("st_busy", 32'(bus.busy), 1);
        @(negedge clk);
        bus.stall = 1'b0;
        #2;
        chk("st_rel_ack",  32'(bus.ins_ack), 1);
        chk("st_rel_ena",  32'(bus.stage_ena), 7);
        chk("st_rel_sv",   32'(bus.stage_valid), 3);
        chk("st_rel_done", 32'(bus.done_valid), 0);
        @(negedge clk);
        bus.ins_req = 1'b0;
        #2;
        chk("st_sv_all", 32'(bus.stage_valid), 7);
        chk("st_done",   32'(bus.done_valid), 1);
        chk("st_dop",    32'(bus.done_op), 2);
        chk("st_occ",    32'(bus.occupancy), 4);

        // asynchronous reset with three ops in flight
        #1;
        rst = 1'b1;
        #1;
        chk("ar_sv",    32'(bus.stage_valid), 0);
        chk("ar_occ",   32'(bus.occupancy), 0);
        chk("ar_busy",  32'(bus.busy), 0);
        chk("ar_empty", 32'(bus.empty), 1);
        chk("ar_full",  32'(bus.full), 0);
        chk("ar_done",  32'(bus.done_valid), 0);
        chk("ar_iop",   32'(bus.issue_op), 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #2;
            chk($sformatf("ar_nodone%0d", i), 32'(bus.done_valid), 0);
            chk($sformatf("ar_nosv%0d", i),   32'(bus.stage_valid), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tag_sort_pipe_ctrl.md
# tag_sort_pipe_ctrl

Issue controller for the multibit-tree tag sorter pipeline. Arbitrates between insert and dequeue requesters and issues at most one operation per cycle into the stage-register chain. Drives the per-stage enables and valid bits, enforces the dequeue read-after-update hazard, and tracks sorter occupancy. Sits between the scheduler front end and the stage registers (stage 1 to stage NUM_STAGES).

## Interface
- NUM_STAGES, 3: pipeline stage registers controlled; range 2..8
- TAG_W, 12: tag width
- DEPTH, 256: sorter capacity in tags
- CNT_W, 9: occupancy width; must hold DEPTH
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ins_req  in  1  insert request; held until acked
- ins_tag  in  TAG_W  tag to insert; stable while ins_req
- ins_ack  out  1  insert granted this cycle (combinational)
- deq_req  in  1  dequeue-min request; held until acked
- deq_ack  out  1  dequeue granted this cycle (combinational)
- stall  in  1  downstream busy; freezes the whole pipeline
- issue_op  out  2  op entering stage 1: 00 none, 01 insert, 10 dequeue
- issue_tag  out  TAG_W  tag entering stage 1; zero for dequeue
- stage_ena  out  NUM_STAGES  per-stage register enable
- stage_valid  out  NUM_STAGES  stage i holds a live op
- done_valid  out  1  op leaves last stage this cycle
- done_op  out  2  op type of the retiring op
- occupancy  out  CNT_W  tags held, counted at issue
- full  out  1  occupancy == DEPTH
- empty  out  1  occupancy == 0
- busy  out  1  state != IDLE

## Operation
- Eligibility: ins_ok = ins_req & ~full & ~stall; deq_ok = deq_req & ~empty & ~stall & ~deq_hazard.
- deq_hazard = a dequeue is valid in any of stages 1..NUM_STAGES-1. It may not be in the last stage, because the tree bitmap is not yet updated.
- Arbitration: when only one is eligible, grant it. When both are eligible, round-robin against last_grant. last_grant updates only on a conflict grant. Reset value of last_grant is dequeue, so insert wins the first conflict.
- On grant: assert the matching ack in the same cycle. At the next edge, register issue_op/issue_tag and set stage_valid[0], with per-stage op type tracked alongside.
- Advance: when ~stall, stage_ena = all ones and valid/op bits shift one stage per cycle. When stall, stage_ena = 0 and all valid/op bits hold.
- Retire: done_valid = stage_valid[NUM_STAGES-1] & ~stall; done_op is that stage's op type.
- Occupancy: +1 at insert grant, -1 at dequeue grant. Only one grant per cycle, so there is no simultaneous update.
- full and empty come from the registered occupancy and reflect a grant from the next cycle on.
- FSM states:
  - IDLE: no valid stages. Goes to RUN on a grant.
  - RUN: goes to HOLD when stall. Goes to IDLE when all stage_valid are 0 and there is no grant this cycle.
  - HOLD: no grants, enables low. Goes to RUN when stall drops.
- Stall in IDLE: stay in IDLE with no grants.
- Reset (asynchronous, any time including mid-operation): state IDLE; all stage_valid, issue_op, issue_tag, done outputs, occupancy and busy are 0; empty 1; full 0; last_grant dequeue. In-flight ops are discarded, not retired.

## Timing
- Grant in cycle t: ack high in t; stage_valid[0] high in t+1; stage_valid[NUM_STAGES-1] and done_valid high in t+NUM_STAGES, plus one cycle per stall cycle.
- Inserts: back-to-back issue possible, one per cycle.
- Dequeue to dequeue: minimum spacing NUM_STAGES cycles. Next deq_ack no earlier than t+NUM_STAGES.
- Insert and dequeue interleave freely; the hazard applies only to dequeue-after-dequeue.
- Stall asserted in cycle t: no ack, enables and done_valid low in cycle t, state HOLD from t+1.
- A request pending across a stall is granted in the first cycle stall is low.
- Acks are combinational from req, stall and registered state only; no path from ins_tag.

## Test plan
- Reset then single insert tag 0x0A5, NUM_STAGES=3: ins_ack at t, issue_op=01 and issue_tag=0x0A5 at t+1, done_valid with done_op=01 at t+3, occupancy 1, busy returns to 0 at t+4.
- Four back-to-back inserts, DEPTH=4, then a fifth ins_req: four acks in consecutive cycles, full=1, fifth never acked until a dequeue retires a slot and lowers occupancy to 3.
- Both requests held continuously with occupancy 2: first conflict grants insert, then dequeue. Dequeues are spaced at least 3 cycles apart with inserts filling the gaps.
- Stall for 2 cycles while ops are in stages 1 and 2: stage_valid frozen, stage_ena=000, no acks, done_valid delayed exactly 2 cycles.
- deq_req with empty=1: deq_ack stays 0. An ins_req issued in the same cycle is acked and the dequeue is acked the next cycle.
- Assert rst asynchronously mid-stream with 3 ops in flight: all stage_valid, occupancy and busy go to 0 immediately, empty=1, and no done_valid for the discarded ops.
